// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// One word request outstanding at a time; ack completes it with data.
interface instruction_fetch_stage_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch front end: PC sequencing, imem handshake, predecode and the IF/ID register.
// HOLD parks an acked word during stall/freeze; DROP waits out a request a redirect orphaned.
module instruction_fetch_stage #(
  parameter logic [29:0] RESET_VECTOR = 30'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_if_i,
  input  logic                         busywait_i,
  input  logic                         branching_i,
  input  logic [29:0]                  branch_target_i,
  instruction_fetch_stage_if.master    imem,
  output logic [29:0]                  instr_o,
  output logic [29:0]                  pc_o,
  output logic                         instr_valid_o,
  output logic [1:0]                   branch_jump_op_o,
  output logic [2:0]                   imm_src_o
);

  typedef struct packed {
    logic [29:0] instr;
    logic [29:0] pc;
    logic        valid;
    logic [1:0]  bj;
    logic [2:0]  imm;
  } ifid_t;

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  localparam ifid_t NOP = '{instr: 30'h0000_0004, pc: 30'h0, valid: 1'b0, bj: 2'b00, imm: 3'd0};

  state_t      state;
  logic [29:0] fetch_pc;
  logic [29:0] redirect_pc;
  ifid_t       hold_q;
  ifid_t       ifid_q;
  ifid_t       fetched;
  logic        advance;
  logic        unused_ok;

  function automatic ifid_t predecode(input logic [31:0] w, input logic [29:0] pc);
    ifid_t r;
    r.instr = w[31:2];
    r.pc    = pc;
    r.valid = 1'b1;
    r.bj    = 2'b00;
    r.imm   = 3'd0;
    case (w[6:2])
      5'b11000:          begin r.bj = 2'b01; r.imm = 3'd2; end
      5'b11011:          begin r.bj = 2'b10; r.imm = 3'd4; end
      5'b11001:          begin r.bj = 2'b11; r.imm = 3'd0; end
      5'b01000:          r.imm = 3'd1;
      5'b01101, 5'b00101: r.imm = 3'd3;
      default:           ;
    endcase
    return r;
  endfunction

  assign advance   = !busywait_i && !stall_if_i;
  assign fetched   = predecode(imem.imem_data, fetch_pc);
  assign unused_ok = &{1'b0, imem.imem_data[1:0]};

  // Request is masked during reset so an abandoned transfer is never re-driven.
  assign imem.imem_req  = !rst_i && (state != S_HOLD);
  assign imem.imem_addr = fetch_pc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_FETCH;
      fetch_pc    <= RESET_VECTOR;
      redirect_pc <= RESET_VECTOR;
      hold_q      <= NOP;
      ifid_q      <= NOP;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem.imem_ack) begin
            if (branching_i) begin
              fetch_pc <= branch_target_i;
              ifid_q   <= NOP;
            end else if (advance) begin
              ifid_q   <= fetched;
              fetch_pc <= fetch_pc + 30'd1;
            end else begin
              hold_q   <= fetched;
              fetch_pc <= fetch_pc + 30'd1;
              state    <= S_HOLD;
            end
          end else if (branching_i) begin
            redirect_pc <= branch_target_i;
            ifid_q      <= NOP;
            state       <= S_DROP;
          end else if (advance) begin
            ifid_q <= NOP;
          end
        end
        S_HOLD: begin
          if (branching_i) begin
            fetch_pc <= branch_target_i;
            ifid_q   <= NOP;
            state    <= S_FETCH;
          end else if (advance) begin
            ifid_q <= hold_q;
            state  <= S_FETCH;
          end
        end
        S_DROP: begin
          // A redirect landing on the ack cycle must win over the older saved target.
          if (branching_i) begin
            redirect_pc <= branch_target_i;
            ifid_q      <= NOP;
            if (imem.imem_ack) begin
              fetch_pc <= branch_target_i;
              state    <= S_FETCH;
            end
          end else begin
            if (imem.imem_ack) begin
              fetch_pc <= redirect_pc;
              state    <= S_FETCH;
            end
            if (advance) ifid_q <= NOP;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign instr_o          = ifid_q.instr;
  assign pc_o             = ifid_q.pc;
  assign instr_valid_o    = ifid_q.valid;
  assign branch_jump_op_o = ifid_q.bj;
  assign imm_src_o        = ifid_q.imm;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: the bench plays instruction memory
// cycle by cycle and checks IF/ID and the request bus against hand-derived values.
module tb_instruction_fetch_stage;
  localparam logic [29:0] RV = 30'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        busy = 1'b0;
  logic        br = 1'b0;
  logic [29:0] tgt = '0;
  logic [29:0] instr, pc;
  logic        vld;
  logic [1:0]  bj;
  logic [2:0]  imm;
  int checks = 0;
  int failures = 0;

  instruction_fetch_stage_if bus();

  instruction_fetch_stage #(.RESET_VECTOR(RV)) dut (
    .clk_i(clk), .rst_i(rst), .stall_if_i(stall), .busywait_i(busy),
    .branching_i(br), .branch_target_i(tgt), .imem(bus.master),
    .instr_o(instr), .pc_o(pc), .instr_valid_o(vld),
    .branch_jump_op_o(bj), .imm_src_o(imm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[24:0], 7'h13};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] data);
    bus.imem_ack  = ack;
    bus.imem_data = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.imem_req, vld, instr, pc, bj, imm} !== {1'b0, 1'b0, 30'h4, 30'h0, 2'b00, 3'd0}) begin
      failures++;
      $display("FAIL reset_ifid req=%b vld=%b instr=%h pc=%h bj=%b imm=%0d", bus.imem_req, vld, instr, pc, bj, imm);
    end
    checks++;
    if (bus.imem_addr !== RV) begin
      failures++; $display("FAIL reset_addr got=%h want=%h", bus.imem_addr, RV);
    end
    rst = 1'b0;
    drive(1'b1, mem_word(RV));
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, RV}) begin
      failures++; $display("FAIL release_req req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, RV);
    end
  endtask

  task automatic test_straight();
    logic [29:0] a;
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      a = RV + 30'(i);
      w = mem_word(a);
      drive(1'b1, w);
      tick();
      checks++;
      if ({vld, pc, instr} !== {1'b1, a, w[31:2]}) begin
        failures++; $display("FAIL straight_ifid vld=%b pc=%h instr=%h want pc=%h instr=%h", vld, pc, instr, a, w[31:2]);
      end
      checks++;
      if (bus.imem_addr !== a + 30'd1) begin
        failures++; $display("FAIL straight_addr got=%h want=%h", bus.imem_addr, a + 30'd1);
      end
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_wait_states();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.imem_req, bus.imem_addr, vld} !== {1'b1, 30'h103, 1'b0}) begin
        failures++; $display("FAIL wait_hold req=%b addr=%h vld=%b want 1/103/0", bus.imem_req, bus.imem_addr, vld);
      end
    end
    w = mem_word(30'h103);
    drive(1'b1, w);
    tick();
    checks++;
    if ({vld, pc, instr, bus.imem_addr} !== {1'b1, 30'h103, w[31:2], 30'h104}) begin
      failures++; $display("FAIL wait_deliver vld=%b pc=%h addr=%h want 1/103/104", vld, pc, bus.imem_addr);
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = mem_word(30'h104);
    stall = 1'b1;
    drive(1'b1, w);
    tick();
    checks++;
    if ({bus.imem_req, vld, pc} !== {1'b0, 1'b1, 30'h103}) begin
      failures++; $display("FAIL stall_buffer req=%b vld=%b pc=%h want 0/1/103", bus.imem_req, vld, pc);
    end
    drive(1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.imem_req, vld, pc} !== {1'b0, 1'b1, 30'h103}) begin
      failures++; $display("FAIL stall_keep req=%b vld=%b pc=%h want 0/1/103", bus.imem_req, vld, pc);
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({vld, pc, instr} !== {1'b1, 30'h104, w[31:2]}) begin
      failures++; $display("FAIL stall_release vld=%b pc=%h instr=%h want 1/104/%h", vld, pc, instr, w[31:2]);
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 30'h105}) begin
      failures++; $display("FAIL stall_next req=%b addr=%h want 1/105", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch_pending();
    logic [31:0] w;
    br = 1'b1; tgt = 30'h200;
    tick();
    br = 1'b0;
    checks++;
    if ({vld, instr, pc} !== {1'b0, 30'h4, 30'h0}) begin
      failures++; $display("FAIL drop_flush vld=%b instr=%h pc=%h want NOP", vld, instr, pc);
    end
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 30'h105}) begin
      failures++; $display("FAIL drop_addr req=%b addr=%h want 1/105", bus.imem_req, bus.imem_addr);
    end
    tick();
    checks++;
    if ({bus.imem_addr, vld} !== {30'h105, 1'b0}) begin
      failures++; $display("FAIL drop_wait addr=%h vld=%b want 105/0", bus.imem_addr, vld);
    end
    drive(1'b1, mem_word(30'h105));
    tick();
    checks++;
    if ({vld, bus.imem_addr} !== {1'b0, 30'h200}) begin
      failures++; $display("FAIL drop_discard vld=%b addr=%h want 0/200", vld, bus.imem_addr);
    end
    w = mem_word(30'h200);
    drive(1'b1, w);
    tick();
    checks++;
    if ({vld, pc, instr, bus.imem_addr} !== {1'b1, 30'h200, w[31:2], 30'h201}) begin
      failures++; $display("FAIL drop_target vld=%b pc=%h addr=%h want 1/200/201", vld, pc, bus.imem_addr);
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_branch_ack_busy();
    busy = 1'b1; br = 1'b1; tgt = 30'h300;
    drive(1'b1, mem_word(30'h201));
    tick();
    busy = 1'b0; br = 1'b0;
    checks++;
    if ({vld, instr, bus.imem_req, bus.imem_addr} !== {1'b0, 30'h4, 1'b1, 30'h300}) begin
      failures++; $display("FAIL ackbr_flush vld=%b instr=%h req=%b addr=%h want 0/4/1/300", vld, instr, bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, mem_word(30'h300));
    tick();
    checks++;
    if ({vld, pc} !== {1'b1, 30'h300}) begin
      failures++; $display("FAIL ackbr_target vld=%b pc=%h want 1/300", vld, pc);
    end
  endtask

  task automatic test_wrap();
    br = 1'b1; tgt = 30'h3FFF_FFFF;
    drive(1'b1, mem_word(30'h301));
    tick();
    br = 1'b0;
    checks++;
    if (bus.imem_addr !== 30'h3FFF_FFFF) begin
      failures++; $display("FAIL wrap_target addr=%h want 3fffffff", bus.imem_addr);
    end
    drive(1'b1, mem_word(30'h3FFF_FFFF));
    tick();
    checks++;
    if ({vld, pc, bus.imem_addr} !== {1'b1, 30'h3FFF_FFFF, 30'h0}) begin
      failures++; $display("FAIL wrap_pc vld=%b pc=%h addr=%h want 1/3fffffff/0", vld, pc, bus.imem_addr);
    end
  endtask

  task automatic test_predecode();
    logic [31:0] words [6] = '{32'h0000_006F, 32'h0000_2023, 32'h0000_0063, 32'h0000_0037, 32'h0000_0067, 32'h0000_0017};
    logic [1:0]  ebj   [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
    logic [2:0]  eimm  [6] = '{3'd4, 3'd1, 3'd2, 3'd3, 3'd0, 3'd3};
    logic [31:0] w;
    for (int i = 0; i < 6; i++) begin
      w = words[i];
      drive(1'b1, w);
      tick();
      checks++;
      if ({vld, bj, imm, instr} !== {1'b1, ebj[i], eimm[i], w[31:2]}) begin
        failures++; $display("FAIL predecode_%0d word=%h bj=%b imm=%0d instr=%h want bj=%b imm=%0d", i, w, bj, imm, instr, ebj[i], eimm[i]);
      end
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_reset_midreq();
    tick();
    rst = 1'b1;
    drive(1'b1, mem_word(30'h7));
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL midreq_req got=%b want 0", bus.imem_req);
    end
    tick();
    checks++;
    if ({vld, instr} !== {1'b0, 30'h4}) begin
      failures++; $display("FAIL midreq_ifid vld=%b instr=%h want 0/4", vld, instr);
    end
    drive(1'b0, 32'h0);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, RV}) begin
      failures++; $display("FAIL midreq_restart req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, RV);
    end
  endtask

  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    test_reset();
    test_straight();
    test_wait_states();
    test_stall();
    test_branch_pending();
    test_branch_ack_busy();
    test_wrap();
    test_predecode();
    test_reset_midreq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
